// File: rtl/conveyor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conveyor_pkg
// Description : Shared types, constants and helpers for the nested conveyor
//               bank (conveyor_bank / conveyor_context).
//               - conveyor_slot_t : packed {finished, fault, data} view of
//                 one slot at the default widths
//               - F_NONE          : "no fault" code
//               - slot_sub()      : modulo slot-index subtraction
// Revision    : 1.0 - initial release
// ============================================================================
package conveyor_pkg;

    localparam int C_WORD_WIDTH          = 32;
    localparam int C_CONVEYOR_ADDR_WIDTH = 4;
    localparam int C_FAULT_ADDR_WIDTH    = 3;

    // Working width of slot_sub(). Callers truncate the result back to the
    // slot index width, which is exact modulo arithmetic for index widths
    // up to this size.
    localparam int C_SLOT_CALC_W = 16;

    localparam logic [C_FAULT_ADDR_WIDTH-1:0] F_NONE = '0;

    typedef struct packed {
        logic                          finished;
        logic [C_FAULT_ADDR_WIDTH-1:0] fault;
        logic [C_WORD_WIDTH-1:0]       data;
    } conveyor_slot_t;

    // head - n, wrapping; the caller keeps the low index bits.
    function automatic logic [C_SLOT_CALC_W-1:0] slot_sub(
        input logic [C_SLOT_CALC_W-1:0] head,
        input logic [C_SLOT_CALC_W-1:0] n
    );
        return head - n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/conveyor_context.sv
`default_nettype none
// ============================================================================
// Module      : conveyor_context
// Description : Storage for one nesting context of the conveyor bank: the
//               slot array, the head pointer and the count of outstanding
//               (reserved but not completed) load slots.
// Ports       :
//   clk, reset              clock, synchronous active-high reset
//   rd_offset  -> rd_addr    head-relative read; rd_addr = head + rd_offset
//   rd_finished/fault/data   contents of slot rd_addr
//   rsv_slot                 head-1, the slot a reserve would allocate
//   pending                  outstanding reservation count (0..SIZE)
//   rsv_en                   allocate head-1 as an unfinished slot
//   cmp_en/slot/fault/data   tagged load completion write
//   ent_en/value/bus         interrupt entry: push value then bus
// Write priority on a shared slot: entry > reserve > completion.
// Revision    : 1.0 - initial release
// ============================================================================
module conveyor_context
    import conveyor_pkg::*;
#(
    parameter int WORD_WIDTH          = C_WORD_WIDTH,
    parameter int CONVEYOR_ADDR_WIDTH = C_CONVEYOR_ADDR_WIDTH,
    parameter int FAULT_ADDR_WIDTH    = C_FAULT_ADDR_WIDTH
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [CONVEYOR_ADDR_WIDTH-1:0] rd_offset,
    output logic [CONVEYOR_ADDR_WIDTH-1:0] rd_addr,
    output logic                           rd_finished,
    output logic [FAULT_ADDR_WIDTH-1:0]    rd_fault,
    output logic [WORD_WIDTH-1:0]          rd_data,
    output logic [CONVEYOR_ADDR_WIDTH-1:0] rsv_slot,
    output logic [CONVEYOR_ADDR_WIDTH:0]   pending,
    input  logic                           rsv_en,
    input  logic                           cmp_en,
    input  logic [CONVEYOR_ADDR_WIDTH-1:0] cmp_slot,
    input  logic [FAULT_ADDR_WIDTH-1:0]    cmp_fault,
    input  logic [WORD_WIDTH-1:0]          cmp_data,
    input  logic                           ent_en,
    input  logic [WORD_WIDTH-1:0]          ent_value,
    input  logic [WORD_WIDTH-1:0]          ent_bus
);

    localparam int C_SIZE = 1 << CONVEYOR_ADDR_WIDTH;
    localparam logic [FAULT_ADDR_WIDTH-1:0]    C_FAULT_NONE = FAULT_ADDR_WIDTH'(F_NONE);
    localparam logic [CONVEYOR_ADDR_WIDTH:0]   C_PEND_ONE   = (CONVEYOR_ADDR_WIDTH+1)'(1);

    logic                           r_fin_q   [0:C_SIZE-1];
    logic [FAULT_ADDR_WIDTH-1:0]    r_fault_q [0:C_SIZE-1];
    logic [WORD_WIDTH-1:0]          r_data_q  [0:C_SIZE-1];
    logic [CONVEYOR_ADDR_WIDTH-1:0] r_head_q;
    logic [CONVEYOR_ADDR_WIDTH:0]   r_pending_q;

    logic                           w_fin_d   [0:C_SIZE-1];
    logic [FAULT_ADDR_WIDTH-1:0]    w_fault_d [0:C_SIZE-1];
    logic [WORD_WIDTH-1:0]          w_data_d  [0:C_SIZE-1];
    logic [CONVEYOR_ADDR_WIDTH-1:0] w_head_d;
    logic [CONVEYOR_ADDR_WIDTH:0]   w_pending_d;

    logic [CONVEYOR_ADDR_WIDTH-1:0] w_head_m1;
    logic [CONVEYOR_ADDR_WIDTH-1:0] w_head_m2;
    logic                           w_cmp_dec;

    assign w_head_m1 = CONVEYOR_ADDR_WIDTH'(slot_sub(C_SLOT_CALC_W'(r_head_q), C_SLOT_CALC_W'(1)));
    assign w_head_m2 = CONVEYOR_ADDR_WIDTH'(slot_sub(C_SLOT_CALC_W'(r_head_q), C_SLOT_CALC_W'(2)));

    // Read port: head-relative address wraps naturally at the index width.
    assign rd_addr     = r_head_q + rd_offset;
    assign rd_finished = r_fin_q[rd_addr];
    assign rd_fault    = r_fault_q[rd_addr];
    assign rd_data     = r_data_q[rd_addr];
    assign rsv_slot    = w_head_m1;
    assign pending     = r_pending_q;

    // A completion with nothing outstanding is a stray tag; the counter is
    // kept from wrapping below zero.
    assign w_cmp_dec = cmp_en && (r_pending_q != '0);

    always_comb begin
        w_fin_d     = r_fin_q;
        w_fault_d   = r_fault_q;
        w_data_d    = r_data_q;
        w_head_d    = r_head_q;
        w_pending_d = r_pending_q;

        if (cmp_en) begin
            w_fin_d[cmp_slot]   = 1'b1;
            w_fault_d[cmp_slot] = cmp_fault;
            w_data_d[cmp_slot]  = cmp_data;
        end

        if (rsv_en) begin
            w_fin_d[w_head_m1]   = 1'b0;
            w_fault_d[w_head_m1] = C_FAULT_NONE;
            w_data_d[w_head_m1]  = '0;
            w_head_d             = w_head_m1;
        end

        // Entry writes are applied last so they override a same-cycle
        // completion aimed at the same slot.
        if (ent_en) begin
            w_fin_d[w_head_m1]   = 1'b1;
            w_fault_d[w_head_m1] = C_FAULT_NONE;
            w_data_d[w_head_m1]  = ent_value;
            w_fin_d[w_head_m2]   = 1'b1;
            w_fault_d[w_head_m2] = C_FAULT_NONE;
            w_data_d[w_head_m2]  = ent_bus;
            w_head_d             = w_head_m2;
        end

        case ({rsv_en, w_cmp_dec})
            2'b10:   w_pending_d = r_pending_q + C_PEND_ONE;
            2'b01:   w_pending_d = r_pending_q - C_PEND_ONE;
            default: w_pending_d = r_pending_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < C_SIZE; i++) begin
                r_fin_q[i]   <= 1'b0;
                r_fault_q[i] <= C_FAULT_NONE;
                r_data_q[i]  <= '0;
            end
            r_head_q    <= '0;
            r_pending_q <= '0;
        end else begin
            r_fin_q     <= w_fin_d;
            r_fault_q   <= w_fault_d;
            r_data_q    <= w_data_d;
            r_head_q    <= w_head_d;
            r_pending_q <= w_pending_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/conveyor_bank.sv
`default_nettype none
// ============================================================================
// Module      : conveyor_bank
// Description : Nested conveyor store. One conveyor_context per interrupt
//               nesting level, tagged out-of-order load completion, and a
//               head-relative operand read with halt/fault for
//               wait-on-conveyor accesses.
// Build option: CONVEYOR_BYPASS_EN - when defined, a completion aimed at the
//               slot being accessed in the active context is forwarded to
//               the access path in the same cycle.
// Ports       :
//   clk, reset                      clock, synchronous active-high reset
//   access_offset, access_check     operand access (offset from head)
//   reserve -> reserve_slot/ctx     load issue slot allocation
//   complete_valid/ctx/slot/fault/data   tagged load completion
//   int_enter, int_value, int_bus   enter next nesting level
//   int_exit                        return to previous level
//   ctx                             active context
//   conveyor_value, halt, fault     access results
//   nest_fault                      one-cycle pulse on illegal enter/exit
// Revision    : 1.0 - initial release
// ============================================================================
module conveyor_bank
    import conveyor_pkg::*;
#(
    parameter int WORD_WIDTH          = 32,
    parameter int CONVEYOR_ADDR_WIDTH = 4,
    parameter int CONTEXTS            = 4,
    parameter int FAULT_ADDR_WIDTH    = 3,
    localparam int CTX_W              = $clog2(CONTEXTS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [CONVEYOR_ADDR_WIDTH-1:0] access_offset,
    input  logic                           access_check,
    input  logic                           reserve,
    output logic [CONVEYOR_ADDR_WIDTH-1:0] reserve_slot,
    output logic [CTX_W-1:0]               reserve_ctx,
    input  logic                           complete_valid,
    input  logic [CTX_W-1:0]               complete_ctx,
    input  logic [CONVEYOR_ADDR_WIDTH-1:0] complete_slot,
    input  logic [FAULT_ADDR_WIDTH-1:0]    complete_fault,
    input  logic [WORD_WIDTH-1:0]          complete_data,
    input  logic                           int_enter,
    input  logic [WORD_WIDTH-1:0]          int_value,
    input  logic [WORD_WIDTH-1:0]          int_bus,
    input  logic                           int_exit,
    output logic [CTX_W-1:0]               ctx,
    output logic [WORD_WIDTH-1:0]          conveyor_value,
    output logic                           halt,
    output logic [FAULT_ADDR_WIDTH-1:0]    fault,
    output logic                           nest_fault
);

    localparam logic [FAULT_ADDR_WIDTH-1:0]  C_FAULT_NONE   = FAULT_ADDR_WIDTH'(F_NONE);
    localparam logic [CONVEYOR_ADDR_WIDTH:0] C_PENDING_FULL = (CONVEYOR_ADDR_WIDTH+1)'(1 << CONVEYOR_ADDR_WIDTH);
    localparam logic [CTX_W-1:0]             C_CTX_ONE      = CTX_W'(1);
    localparam logic [CTX_W-1:0]             C_CTX_LAST     = CTX_W'(CONTEXTS - 1);

    logic [CTX_W-1:0] r_ctx_q;
    logic [CTX_W-1:0] w_ctx_d;
    logic             r_nest_fault_q;
    logic             w_nest_fault_d;

    logic [CONVEYOR_ADDR_WIDTH-1:0] w_rd_addr  [0:CONTEXTS-1];
    logic                           w_rd_fin   [0:CONTEXTS-1];
    logic [FAULT_ADDR_WIDTH-1:0]    w_rd_fault [0:CONTEXTS-1];
    logic [WORD_WIDTH-1:0]          w_rd_data  [0:CONTEXTS-1];
    logic [CONVEYOR_ADDR_WIDTH-1:0] w_rsv_slot [0:CONTEXTS-1];
    logic [CONVEYOR_ADDR_WIDTH:0]   w_pending  [0:CONTEXTS-1];

    logic             w_sel_fin;
    logic [FAULT_ADDR_WIDTH-1:0] w_sel_fault;
    logic [WORD_WIDTH-1:0]       w_sel_data;

    logic             w_ctx_full;
    logic             w_halt;
    logic             w_rsv_commit;
    logic             w_enter;
    logic             w_exit;
    logic [CTX_W-1:0] w_ctx_next;

    // ------------------------------------------------------------------
    // Nesting control. int_exit has priority over int_enter.
    // ------------------------------------------------------------------
    assign w_ctx_next = r_ctx_q + C_CTX_ONE;
    assign w_exit     = int_exit && (r_ctx_q != '0);
    assign w_enter    = int_enter && !int_exit && (r_ctx_q != C_CTX_LAST);

    assign w_nest_fault_d = (int_exit && (r_ctx_q == '0)) ||
                            (int_enter && !int_exit && (r_ctx_q == C_CTX_LAST));

    always_comb begin
        w_ctx_d = r_ctx_q;
        if (w_exit) begin
            w_ctx_d = r_ctx_q - C_CTX_ONE;
        end else if (w_enter) begin
            w_ctx_d = w_ctx_next;
        end
    end

    // ------------------------------------------------------------------
    // Access path (active context), with optional completion forwarding.
    // ------------------------------------------------------------------
`ifdef CONVEYOR_BYPASS_EN
    logic w_bypass_hit;
    assign w_bypass_hit = complete_valid && (complete_ctx == r_ctx_q) &&
                          (complete_slot == w_rd_addr[r_ctx_q]);

    always_comb begin
        w_sel_fin   = w_rd_fin[r_ctx_q];
        w_sel_fault = w_rd_fault[r_ctx_q];
        w_sel_data  = w_rd_data[r_ctx_q];
        if (w_bypass_hit) begin
            w_sel_fin   = 1'b1;
            w_sel_fault = complete_fault;
            w_sel_data  = complete_data;
        end
    end
`else
    assign w_sel_fin   = w_rd_fin[r_ctx_q];
    assign w_sel_fault = w_rd_fault[r_ctx_q];
    assign w_sel_data  = w_rd_data[r_ctx_q];
`endif

    // A reserve alongside int_enter is stalled so it retries once the
    // interrupt context is active; a reserve with every slot outstanding
    // waits for a completion.
    assign w_ctx_full   = (w_pending[r_ctx_q] == C_PENDING_FULL);
    assign w_halt       = (access_check && !w_sel_fin) ||
                          (reserve && w_ctx_full) ||
                          (reserve && int_enter);
    assign w_rsv_commit = reserve && !w_halt;

    // ------------------------------------------------------------------
    // Per-context storage
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < CONTEXTS; gi++) begin : g_ctx
        logic [CTX_W-1:0] w_id;
        logic             w_rsv_en;
        logic             w_cmp_en;
        logic             w_ent_en;

        assign w_id     = CTX_W'(gi);
        assign w_rsv_en = w_rsv_commit && (r_ctx_q == w_id);
        assign w_cmp_en = complete_valid && (complete_ctx == w_id);
        assign w_ent_en = w_enter && (w_ctx_next == w_id);

        conveyor_context #(
            .WORD_WIDTH          (WORD_WIDTH),
            .CONVEYOR_ADDR_WIDTH (CONVEYOR_ADDR_WIDTH),
            .FAULT_ADDR_WIDTH    (FAULT_ADDR_WIDTH)
        ) u_context (
            .clk         (clk),
            .reset       (reset),
            .rd_offset   (access_offset),
            .rd_addr     (w_rd_addr[gi]),
            .rd_finished (w_rd_fin[gi]),
            .rd_fault    (w_rd_fault[gi]),
            .rd_data     (w_rd_data[gi]),
            .rsv_slot    (w_rsv_slot[gi]),
            .pending     (w_pending[gi]),
            .rsv_en      (w_rsv_en),
            .cmp_en      (w_cmp_en),
            .cmp_slot    (complete_slot),
            .cmp_fault   (complete_fault),
            .cmp_data    (complete_data),
            .ent_en      (w_ent_en),
            .ent_value   (int_value),
            .ent_bus     (int_bus)
        );
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctx_q        <= '0;
            r_nest_fault_q <= 1'b0;
        end else begin
            r_ctx_q        <= w_ctx_d;
            r_nest_fault_q <= w_nest_fault_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ctx            = r_ctx_q;
    assign nest_fault     = r_nest_fault_q;
    assign halt           = w_halt;
    assign conveyor_value = w_sel_data;
    assign fault          = access_check ? w_sel_fault : C_FAULT_NONE;
    assign reserve_slot   = w_rsv_slot[r_ctx_q];
    assign reserve_ctx    = r_ctx_q;

endmodule
`default_nettype wire

// File: tb/tb_conveyor_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_conveyor_bank
// Description : Self-checking bench for conveyor_bank (default parameters).
//               Expected values are queued when stimulus is applied and
//               popped when the corresponding DUT output is sampled.
//               Completion-cycle expectations follow CONVEYOR_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conveyor_bank;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  access_offset;
    logic        access_check;
    logic        reserve;
    logic [3:0]  reserve_slot;
    logic [1:0]  reserve_ctx;
    logic        complete_valid;
    logic [1:0]  complete_ctx;
    logic [3:0]  complete_slot;
    logic [2:0]  complete_fault;
    logic [31:0] complete_data;
    logic        int_enter;
    logic [31:0] int_value;
    logic [31:0] int_bus;
    logic        int_exit;
    logic [1:0]  ctx;
    logic [31:0] conveyor_value;
    logic        halt;
    logic [2:0]  fault;
    logic        nest_fault;

    int          vec  = 0;
    int          miss = 0;
    logic [31:0] exp_q [$];
    logic [31:0] e;

    conveyor_bank dut (
        .clk            (clk),
        .reset          (reset),
        .access_offset  (access_offset),
        .access_check   (access_check),
        .reserve        (reserve),
        .reserve_slot   (reserve_slot),
        .reserve_ctx    (reserve_ctx),
        .complete_valid (complete_valid),
        .complete_ctx   (complete_ctx),
        .complete_slot  (complete_slot),
        .complete_fault (complete_fault),
        .complete_data  (complete_data),
        .int_enter      (int_enter),
        .int_value      (int_value),
        .int_bus        (int_bus),
        .int_exit       (int_exit),
        .ctx            (ctx),
        .conveyor_value (conveyor_value),
        .halt           (halt),
        .fault          (fault),
        .nest_fault     (nest_fault)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        access_offset  = '0;
        access_check   = 1'b0;
        reserve        = 1'b0;
        complete_valid = 1'b0;
        complete_ctx   = '0;
        complete_slot  = '0;
        complete_fault = '0;
        complete_data  = '0;
        int_enter      = 1'b0;
        int_value      = '0;
        int_bus        = '0;
        int_exit       = 1'b0;
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        access_check = 1'b1;
        access_offset = 4'd0;
        exp_q.push_back(32'd1);   // halt
        exp_q.push_back(32'd0);   // ctx
        exp_q.push_back(32'd0);   // value
        exp_q.push_back(32'd0);   // nest_fault
        exp_q.push_back(32'd15);  // reserve_slot
        exp_q.push_back(32'd0);   // fault
        #2;
        e = exp_q.pop_front(); vec++;
        if (32'(halt) !== e) begin miss++; $display("FAIL reset_halt: got %0h want %0h", halt, e); end
        e = exp_q.pop_front(); vec++;
        if (32'(ctx) !== e) begin miss++; $display("FAIL reset_ctx: got %0h want %0h", ctx, e); end
        e = exp_q.pop_front(); vec++;
        if (conveyor_value !== e) begin miss++; $display("FAIL reset_value: got %0h want %0h", conveyor_value, e); end
        e = exp_q.pop_front(); vec++;
        if (32'(nest_fault) !== e) begin miss++; $display("FAIL reset_nest_fault: got %0h want %0h", nest_fault, e); end
        e = exp_q.pop_front(); vec++;
        if (32'(reserve_slot) !== e) begin miss++; $display("FAIL reset_reserve_slot: got %0h want %0h", reserve_slot, e); end
        e = exp_q.pop_front(); vec++;
        if (32'(fault) !== e) begin miss++; $display("FAIL reset_fault: got %0h want %0h", fault, e); end
    endtask

    task automatic test_reserve_complete();
        do_reset();
        reserve = 1'b1;
        exp_q.push_back(32'd15);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        #2;
        e = exp_q.pop_front(); vec++;
        if (32'(reserve_slot) !== e) begin miss++; $display("FAIL rc_reserve_slot: got %0h want %0h", reserve_slot, e); end
        e = exp_q.pop_front(); vec++;
        if (32'(reserve_ctx) !== e) begin miss++; $display("FAIL rc_reserve_ctx: got %0h want %0h", reserve_ctx, e); end
        e = exp_q.pop_front(); vec++;
        if (32'(halt) !== e) begin miss++; $display("FAIL rc_reserve_halt: got %0h want %0h", halt, e); end
        step();
        reserve        = 1'b0;
        complete_valid = 1'b1;
        complete_ctx   = 2'd0;
        complete_slot  = 4'd15;
        complete_fault = 3'd0;
        complete_data  = 32'hDEADBEEF;
        access_check   = 1'b1;
        access_offset  = 4'd0;
`ifdef CONVEYOR_BYPASS_EN
        exp_q.push_back(32'd0);
        exp_q.push_back(32'hDEADBEEF);
`else
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd0);
`endif
        #2;
        e = exp_q.pop_front(); vec++;
        if (32'(halt) !== e) begin miss++; $display("FAIL rc_cmp_cycle_halt: got %0h want %0h", halt, e); end
        e = exp_q.pop_front(); vec++;
        if (conveyor_value !== e) begin miss++; $display("FAIL rc_cmp_cycle_value: got %0h want %0h", conveyor_value, e); end
        step();
        complete_valid = 1'b0;
        exp_q.push_back(32'd0);
        exp_q.push_back(32'hDEADBEEF);
        #2;
        e = exp_q.pop_front(); vec++;
        if (32'(halt) !== e) begin miss++; $display("FAIL rc_next_halt: got %0h want %0h", halt, e); end
        e = exp_q.pop_front(); vec++;
        if (conveyor_value !== e) begin miss++; $display("FAIL rc_next_value: got %0h want %0h", conveyor_value, e); end
    endtask

    task automatic test_full();
        do_reset();
        reserve = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(32'((15 - i) & 15));
            exp_q.push_back(32'd0);
            #2;
            e = exp_q.pop_front(); vec++;
            if (32'(reserve_slot) !== e) begin miss++; $display("FAIL full_slot[%0d]: got %0h want %0h", i, reserve_slot, e); end
            e = exp_q.pop_front(); vec++;
            if (32'(halt) !== e) begin miss++; $display("FAIL full_halt[%0d]: got %0h want %0h", i, halt, e); end
            step();
        end
        // 17th reserve: every slot outstanding, head back at 0
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd15);
        #2;
        e = exp_q.pop_front(); vec++;
        if (32'(halt) !== e) begin miss++; $display("FAIL full_17_halt: got %0h want %0h", halt, e); end
        e = exp_q.pop_front(); vec++;
        if (32'(reserve_slot) !== e) begin miss++; $display("FAIL full_17_slot: got %0h want %0h", reserve_slot, e); end
        step();
        exp_q.push_back(32'd15);
        #2;
        e = exp_q.pop_front(); vec++;
        if (32'(reserve_slot) !== e) begin miss++; $display("FAIL full_head_held: got %0h want %0h", reserve_slot, e); end
        complete_valid = 1'b1;
        complete_ctx   = 2'd0;
        complete_slot  = 4'd15;
        complete_data  = 32'h00000F0F;
        exp_q.push_back(32'd1);
        #1;
        e = exp_q.pop_front(); vec++;
        if (32'(halt) !== e) begin miss++; $display("FAIL full_cmp_cycle_halt: got %0h want %0h", halt, e); end
        step();
        complete_valid = 1'b0;
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd15);
        #2;
        e = exp_q.pop_front(); vec++;
        if (32'(halt) !== e) begin miss++; $display("FAIL full_resume_halt: got %0h want %0h", halt, e); end
        e = exp_q.pop_front(); vec++;
        if (32'(reserve_slot) !== e) begin miss++; $display("FAIL full_resume_slot: got %0h want %0h", reserve_slot, e); end
        step();
        reserve       = 1'b0;
        access_check  = 1'b1;
        access_offset = 4'd0;
        exp_q.push_back(32'd1);  // slot 15 re-reserved, unfinished
        #2;
        e = exp_q.pop_front(); vec++;
        if (32'(halt) !== e) begin miss++; $display("FAIL full_rereserved_halt: got %0h want %0h", halt, e); end
    endtask

    task automatic test_nesting();
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            int_enter = 1'b1;
            int_value = 32'(i);
            int_bus   = 32'(i * 16);
            step();
            int_enter = 1'b0;
            exp_q.push_back(32'(i));
            #2;
            e = exp_q.pop_front(); vec++;
            if (32'(ctx) !== e) begin miss++; $display("FAIL nest_ctx[%0d]: got %0h want %0h", i, ctx, e); end
        end
        access_check  = 1'b1;
        access_offset = 4'd0;
        exp_q.push_back(32'h30);
        exp_q.push_back(32'd0);
        #1;
        e = exp_q.pop_front(); vec++;
        if (conveyor_value !== e) begin miss++; $display("FAIL nest_off0_value: got %0h want %0h", conveyor_value, e); end
        e = exp_q.pop_front(); vec++;
        if (32'(halt) !== e) begin miss++; $display("FAIL nest_off0_halt: got %0h want %0h", halt, e); end
        access_offset = 4'd1;
        exp_q.push_back(32'd3);
        #1;
        e = exp_q.pop_front(); vec++;
        if (conveyor_value !== e) begin miss++; $display("FAIL nest_off1_value: got %0h want %0h", conveyor_value, e); end
        access_offset = 4'd0;
        int_enter = 1'b1;
        step();
        int_enter = 1'b0;
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd3);
        #2;
        e = exp_q.pop_front(); vec++;
        if (32'(nest_fault) !== e) begin miss++; $display("FAIL nest_over_fault: got %0h want %0h", nest_fault, e); end
        e = exp_q.pop_front(); vec++;
        if (32'(ctx) !== e) begin miss++; $display("FAIL nest_over_ctx: got %0h want %0h", ctx, e); end
        step();
        exp_q.push_back(32'd0);
        #2;
        e = exp_q.pop_front(); vec++;
        if (32'(nest_fault) !== e) begin miss++; $display("FAIL nest_fault_pulse: got %0h want %0h", nest_fault, e); end
        int_exit = 1'b1;
        step();
        int_exit = 1'b0;
        exp_q.push_back(32'd2);
        exp_q.push_back(32'h20);
        #2;
        e = exp_q.pop_front(); vec++;
        if (32'(ctx) !== e) begin miss++; $display("FAIL nest_exit_ctx: got %0h want %0h", ctx, e); end
        e = exp_q.pop_front(); vec++;
        if (conveyor_value !== e) begin miss++; $display("FAIL nest_exit_value: got %0h want %0h", conveyor_value, e); end
        for (int i = 0; i < 2; i++) begin
            int_exit = 1'b1;
            step();
        end
        step();  // third exit issued at ctx 0
        int_exit = 1'b0;
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd0);
        #2;
        e = exp_q.pop_front(); vec++;
        if (32'(nest_fault) !== e) begin miss++; $display("FAIL nest_under_fault: got %0h want %0h", nest_fault, e); end
        e = exp_q.pop_front(); vec++;
        if (32'(ctx) !== e) begin miss++; $display("FAIL nest_under_ctx: got %0h want %0h", ctx, e); end
    endtask

    task automatic test_cross_ctx();
        do_reset();
        reserve = 1'b1;
        step();
        reserve   = 1'b0;
        int_enter = 1'b1;
        int_value = 32'h0000AAAA;
        int_bus   = 32'h0000BBBB;
        step();
        int_enter      = 1'b0;
        complete_valid = 1'b1;
        complete_ctx   = 2'd0;
        complete_slot  = 4'd15;
        complete_data  = 32'h12345678;
        step();
        complete_valid = 1'b0;
        access_check   = 1'b1;
        access_offset  = 4'd0;
        exp_q.push_back(32'd1);
        exp_q.push_back(32'h0000BBBB);
        #2;
        e = exp_q.pop_front(); vec++;
        if (32'(ctx) !== e) begin miss++; $display("FAIL cross_ctx1: got %0h want %0h", ctx, e); end
        e = exp_q.pop_front(); vec++;
        if (conveyor_value !== e) begin miss++; $display("FAIL cross_bus: got %0h want %0h", conveyor_value, e); end
        access_offset = 4'd1;
        exp_q.push_back(32'h0000AAAA);
        #1;
        e = exp_q.pop_front(); vec++;
        if (conveyor_value !== e) begin miss++; $display("FAIL cross_value: got %0h want %0h", conveyor_value, e); end
        access_offset = 4'd2;
        exp_q.push_back(32'd1);
        #1;
        e = exp_q.pop_front(); vec++;
        if (32'(halt) !== e) begin miss++; $display("FAIL cross_ctx1_untouched: got %0h want %0h", halt, e); end
        int_exit = 1'b1;
        step();
        int_exit      = 1'b0;
        access_offset = 4'd0;
        exp_q.push_back(32'd0);
        exp_q.push_back(32'h12345678);
        exp_q.push_back(32'd0);
        #2;
        e = exp_q.pop_front(); vec++;
        if (32'(ctx) !== e) begin miss++; $display("FAIL cross_ctx0: got %0h want %0h", ctx, e); end
        e = exp_q.pop_front(); vec++;
        if (conveyor_value !== e) begin miss++; $display("FAIL cross_ctx0_data: got %0h want %0h", conveyor_value, e); end
        e = exp_q.pop_front(); vec++;
        if (32'(halt) !== e) begin miss++; $display("FAIL cross_ctx0_halt: got %0h want %0h", halt, e); end
    endtask

    task automatic test_fault();
        do_reset();
        reserve = 1'b1;
        step();
        reserve        = 1'b0;
        complete_valid = 1'b1;
        complete_ctx   = 2'd0;
        complete_slot  = 4'd15;
        complete_fault = 3'd3;
        complete_data  = 32'h00000055;
        access_check   = 1'b1;
        access_offset  = 4'd0;
`ifdef CONVEYOR_BYPASS_EN
        exp_q.push_back(32'd3);
        exp_q.push_back(32'd0);
`else
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd1);
`endif
        #2;
        e = exp_q.pop_front(); vec++;
        if (32'(fault) !== e) begin miss++; $display("FAIL fault_cmp_cycle: got %0h want %0h", fault, e); end
        e = exp_q.pop_front(); vec++;
        if (32'(halt) !== e) begin miss++; $display("FAIL fault_cmp_cycle_halt: got %0h want %0h", halt, e); end
        step();
        complete_valid = 1'b0;
        exp_q.push_back(32'd3);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'h00000055);
        #2;
        e = exp_q.pop_front(); vec++;
        if (32'(fault) !== e) begin miss++; $display("FAIL fault_code: got %0h want %0h", fault, e); end
        e = exp_q.pop_front(); vec++;
        if (32'(halt) !== e) begin miss++; $display("FAIL fault_halt: got %0h want %0h", halt, e); end
        e = exp_q.pop_front(); vec++;
        if (conveyor_value !== e) begin miss++; $display("FAIL fault_data: got %0h want %0h", conveyor_value, e); end
        access_check = 1'b0;
        exp_q.push_back(32'd0);
        #1;
        e = exp_q.pop_front(); vec++;
        if (32'(fault) !== e) begin miss++; $display("FAIL fault_unchecked: got %0h want %0h", fault, e); end
        // Disturb state further, then reset mid-sequence.
        reserve = 1'b1;
        step();
        reserve   = 1'b0;
        int_enter = 1'b1;
        int_value = 32'd9;
        int_bus   = 32'd9;
        step();
        int_enter = 1'b0;
        reset     = 1'b1;
        step();
        reset         = 1'b0;
        access_check  = 1'b1;
        access_offset = 4'd15;  // head 0 -> slot 15, finished before reset
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd15);
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd0);
        #2;
        e = exp_q.pop_front(); vec++;
        if (32'(ctx) !== e) begin miss++; $display("FAIL midreset_ctx: got %0h want %0h", ctx, e); end
        e = exp_q.pop_front(); vec++;
        if (32'(nest_fault) !== e) begin miss++; $display("FAIL midreset_nest_fault: got %0h want %0h", nest_fault, e); end
        e = exp_q.pop_front(); vec++;
        if (32'(reserve_slot) !== e) begin miss++; $display("FAIL midreset_head: got %0h want %0h", reserve_slot, e); end
        e = exp_q.pop_front(); vec++;
        if (32'(halt) !== e) begin miss++; $display("FAIL midreset_halt: got %0h want %0h", halt, e); end
        e = exp_q.pop_front(); vec++;
        if (conveyor_value !== e) begin miss++; $display("FAIL midreset_value: got %0h want %0h", conveyor_value, e); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        reserve = 1'b1;
        step();
        step();
        step();
        reserve        = 1'b0;          // slots 15, 14, 13 outstanding, head 13
        complete_valid = 1'b1;
        complete_ctx   = 2'd0;
        complete_fault = 3'd0;
        complete_slot  = 4'd14;
        complete_data  = 32'h00000B14;
        step();
        complete_slot  = 4'd13;
        complete_data  = 32'h00000B13;
        reserve        = 1'b1;
        exp_q.push_back(32'd12);
        exp_q.push_back(32'd0);
        #2;
        e = exp_q.pop_front(); vec++;
        if (32'(reserve_slot) !== e) begin miss++; $display("FAIL b2b_reserve_slot: got %0h want %0h", reserve_slot, e); end
        e = exp_q.pop_front(); vec++;
        if (32'(halt) !== e) begin miss++; $display("FAIL b2b_reserve_halt: got %0h want %0h", halt, e); end
        step();
        reserve       = 1'b0;
        complete_slot = 4'd15;
        complete_data = 32'h00000B15;
        step();
        complete_valid = 1'b0;
        access_check   = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            access_offset = 4'(i);
            exp_q.push_back(32'h00000B12 + 32'(i));
            exp_q.push_back(32'd0);
            #1;
            e = exp_q.pop_front(); vec++;
            if (conveyor_value !== e) begin miss++; $display("FAIL b2b_value[%0d]: got %0h want %0h", i, conveyor_value, e); end
            e = exp_q.pop_front(); vec++;
            if (32'(halt) !== e) begin miss++; $display("FAIL b2b_halt[%0d]: got %0h want %0h", i, halt, e); end
        end
        access_offset = 4'd0;
        exp_q.push_back(32'd1);
        #1;
        e = exp_q.pop_front(); vec++;
        if (32'(halt) !== e) begin miss++; $display("FAIL b2b_pending_halt: got %0h want %0h", halt, e); end
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        test_reset();
        test_reserve_complete();
        test_full();
        test_nesting();
        test_cross_ctx();
        test_fault();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/conveyor_bank.md
Name: conveyor_bank

Overview:
- Next-generation conveyor store: CONTEXTS nested conveyor contexts, one per interrupt nesting level, replacing the fixed main/interrupt pair.
- Adds out-of-order tagged load completion, which replaces the single load_last path.
- Sits between the decode stage, the memory/load pipelines and the interrupt controller.
- Supplies the operand at a head-relative slot, plus halt and fault for the wait-on-conveyor access.

Parameters:
- WORD_WIDTH, 32, data word width.
- CONVEYOR_ADDR_WIDTH, 4, log2 of slots per context (CONVEYOR_SIZE = 1 << CONVEYOR_ADDR_WIDTH).
- CONTEXTS, 4, number of nesting contexts, minimum 2 (CTX_W = $clog2(CONTEXTS)).
- FAULT_ADDR_WIDTH, 3, fault code width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- access_offset  in  CONVEYOR_ADDR_WIDTH  slot offset from the current head.
- access_check  in  1  wait-on-conveyor access; halts if the slot is not finished.
- reserve  in  1  allocate a pending slot at head-1 (load issue).
- reserve_slot  out  CONVEYOR_ADDR_WIDTH  tag of the allocated slot; equals head-1.
- reserve_ctx  out  CTX_W  context of the allocation.
- complete_valid  in  1  load completion strobe.
- complete_ctx  in  CTX_W  completion context tag.
- complete_slot  in  CONVEYOR_ADDR_WIDTH  completion slot tag.
- complete_fault  in  FAULT_ADDR_WIDTH  completion fault code.
- complete_data  in  WORD_WIDTH  completion data.
- int_enter  in  1  enter the next nesting level.
- int_value, int_bus  in  WORD_WIDTH  words pushed into the new context on entry.
- int_exit  in  1  return to the previous context.
- ctx  out  CTX_W  active context.
- conveyor_value  out  WORD_WIDTH  data of the accessed slot.
- halt  out  1  stall request.
- fault  out  FAULT_ADDR_WIDTH  fault of the accessed slot when access_check is set; F_NONE otherwise.
- nest_fault  out  1  one-cycle pulse on an illegal entry or exit.

Behaviour:
- Reset:
  - all slots = {finished 0, F_NONE, 0}.
  - all heads = 0; all pending counters = 0; ctx = 0.
  - nest_fault = 0; combinational outputs follow from this state.
- Slot format: {finished, fault, data}.
- Access path (combinational):
  - a = head[ctx] + access_offset, modulo CONVEYOR_SIZE.
  - conveyor_value comes from slot[ctx][a], with completion bypass (see Optional Feature).
- halt is set when any of:
  - access_check && !finished.
  - reserve && pending[ctx] == CONVEYOR_SIZE (all slots outstanding).
  - reserve && int_enter (retry the reserve after the interrupt).
- Reserve (when not halted):
  - slot[ctx][head-1] <= {0, F_NONE, 0}.
  - head[ctx] <= head-1; pending[ctx] += 1.
  - reserve_slot and reserve_ctx are valid in the same cycle.
- Completion:
  - slot[complete_ctx][complete_slot] <= {1, complete_fault, complete_data}.
  - pending[complete_ctx] -= 1.
  - Completion and reserve in the same cycle on the same context leave pending unchanged.
- int_enter, when ctx < CONTEXTS-1:
  - n = ctx+1.
  - slot[n][head[n]-1] <= {1, F_NONE, int_value}.
  - slot[n][head[n]-2] <= {1, F_NONE, int_bus}.
  - head[n] -= 2; ctx <= n.
  - Reserve is suppressed that cycle.
- int_enter when ctx == CONTEXTS-1: no state change; nest_fault pulses next cycle.
- int_exit:
  - when ctx > 0: ctx <= ctx-1.
  - when ctx == 0: ignored, nest_fault pulses.
  - Pending loads of the exited context still complete into its storage.
- int_enter && int_exit in the same cycle: int_exit wins; int_enter is dropped (the controller guarantees it does not assert both).
- A completion targeting a slot written by int_enter in the same cycle: int_enter wins; pending is still decremented.
- Wrap-around: head arithmetic is modulo CONVEYOR_SIZE in every case, with no error.
- Latency: a completion is visible to an access the next cycle, or the same cycle with bypass.

Optional Feature:
- CONVEYOR_BYPASS_EN defined: if complete_valid && complete_ctx == ctx && complete_slot == a, the access path returns the completion word, finished = 1 and complete_fault in the same cycle.
- Undefined: no bypass; a same-cycle completion to the accessed slot halts one extra cycle. Saves a comparator and a mux on the critical path.

Decomposition:
- conveyor_pkg holds:
  - typedef conveyor_slot_t (packed {finished, fault, data});
  - the F_NONE constant reuse;
  - helper function slot_sub(head, n).
- Sub-module conveyor_context: one context's storage, head and pending counter. It has write ports for reserve, completion and the two entry writes, and a read port.
- conveyor_context is instantiated CONTEXTS times by a generate loop.

Test Plan:
- Reset, then access_check, offset 0 -> halt = 1, ctx = 0, conveyor_value = 0.
- Reserve (reserve_slot = 15), complete ctx 0, slot 15, data 0xDEADBEEF, fault F_NONE -> next cycle access offset 0 gives 0xDEADBEEF and halt = 0. With CONVEYOR_BYPASS_EN the value appears in the completion cycle.
- 16 reserves with no completion -> 17th reserve halts and the head is unchanged; one completion -> the reserve proceeds.
- From ctx 0, 3 int_enter (value 1..3, bus 0x10..0x30) -> ctx = 3, offset 0 = 0x30, offset 1 = 3; a 4th int_enter gives nest_fault = 1 and ctx stays 3.
- Reserve in ctx 0, int_enter, completion tagged ctx 0, int_exit -> ctx 0 slot finished with the correct data; ctx 1 untouched.
- Completion with fault 3 to the accessed slot, with access_check -> fault = 3, halt = 0; reset asserted mid-sequence -> all state returns to reset values the next cycle.
